// File: rtl/seg7_capture_decoder.sv
`timescale 1ns/1ps
// seg7_capture_decoder
// Samples an asynchronous active-low abcdefg segment bus, filters it for
// stability, decodes accepted patterns back to a digit and checks that the
// digit stream follows a +1 modulo counting sequence.
// Optional build macro SEG7_HEX_EN: also decode A..F (digits 10..15) and
// count modulo 16 instead of modulo 10.
//
// Handshake/pulse semantics: digit_valid, illegal and seq_err are single-cycle
// pulses with no ready/backpressure; a consumer must sample them every cycle.
// digit and err_count are held levels that change only alongside an event.
module seg7_capture_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_in,
    input  logic                 clear,
    output logic [3:0]           digit,
    output logic                 digit_valid,
    output logic                 illegal,
    output logic                 seq_locked,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_LOCKED   = 2'd2
    } seq_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
`ifdef SEG7_HEX_EN
    localparam logic [3:0] LAST_DIGIT = 4'd15;
`else
    localparam logic [3:0] LAST_DIGIT = 4'd9;
`endif

    // Returns {legal, value}; blank and unknown patterns return legal=0.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        case (p)
            7'b0000001: decode_seg = {1'b1, 4'd0};
            7'b1001111: decode_seg = {1'b1, 4'd1};
            7'b0010010: decode_seg = {1'b1, 4'd2};
            7'b0000110: decode_seg = {1'b1, 4'd3};
            7'b1001100: decode_seg = {1'b1, 4'd4};
            7'b0100100: decode_seg = {1'b1, 4'd5};
            7'b0100000: decode_seg = {1'b1, 4'd6};
            7'b0001111: decode_seg = {1'b1, 4'd7};
            7'b0000000: decode_seg = {1'b1, 4'd8};
            7'b0001100: decode_seg = {1'b1, 4'd9};
`ifdef SEG7_HEX_EN
            7'b0001000: decode_seg = {1'b1, 4'd10};
            7'b1100000: decode_seg = {1'b1, 4'd11};
            7'b0110001: decode_seg = {1'b1, 4'd12};
            7'b1000010: decode_seg = {1'b1, 4'd13};
            7'b0110000: decode_seg = {1'b1, 4'd14};
            7'b0111000: decode_seg = {1'b1, 4'd15};
`endif
            default:    decode_seg = {1'b0, 4'd0};
        endcase
    endfunction

    logic [6:0]       sync1, sync2, candidate, accepted;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic [4:0]       dec;
    logic             cand_legal, cand_illegal;
    logic [3:0]       cand_value;

    seq_state_t       state, state_next;
    logic [3:0]       last, last_next, exp_digit;
    logic             seq_err_next;
    logic             err_event;

    // Two-flop synchronizer; sync2 is the only view of seg_in used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= SEG_BLANK;
            sync2 <= SEG_BLANK;
        end else begin
            sync1 <= seg_in;
            sync2 <= sync1;
        end
    end

    // Stability filter: restart the hold count on any change of the synced bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate <= SEG_BLANK;
            accepted  <= SEG_BLANK;
            cnt       <= '0;
        end else begin
            if (sync2 != candidate) begin
                candidate <= sync2;
                cnt       <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (accept) begin
                accepted <= candidate;
            end
        end
    end

    // Acceptance and classification of the held candidate pattern.
    always_comb begin
        accept       = (cnt == CNT_MAX) && (candidate != accepted);
        dec          = decode_seg(candidate);
        cand_legal   = dec[4];
        cand_value   = dec[3:0];
        cand_illegal = !dec[4] && (candidate != SEG_BLANK);
    end

    // Registered decode result and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            digit_valid <= accept && cand_legal;
            illegal     <= accept && cand_illegal;
            if (accept && cand_legal) begin
                digit <= cand_value;
            end
        end
    end

    // Sequence checker next-state: advances only on an accepted pattern.
    always_comb begin
        state_next   = state;
        last_next    = last;
        seq_err_next = 1'b0;
        exp_digit    = (last == LAST_DIGIT) ? 4'd0 : last + 4'd1;
        if (accept) begin
            if (cand_legal) begin
                last_next = cand_value;
                case (state)
                    ST_UNLOCKED: state_next = ST_ARMED;
                    ST_ARMED:    state_next = (cand_value == exp_digit) ? ST_LOCKED : ST_ARMED;
                    ST_LOCKED: begin
                        if (cand_value != exp_digit) begin
                            seq_err_next = 1'b1;
                            state_next   = ST_ARMED;
                        end
                    end
                    default:     state_next = ST_UNLOCKED;
                endcase
            end else begin
                state_next = ST_UNLOCKED;
            end
        end
        // clear drops the lock but lets a coincident seq_err pulse through.
        if (clear) begin
            state_next = ST_UNLOCKED;
        end
    end

    // Sequence checker state register and its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_UNLOCKED;
            last       <= 4'd0;
            seq_locked <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            state      <= state_next;
            last       <= last_next;
            seq_locked <= (state_next == ST_LOCKED);
            seq_err    <= seq_err_next;
        end
    end

    assign err_event = (accept && cand_illegal) || seq_err_next;

    // Saturating error counter; clear takes priority over a coincident event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= '0;
        end else if (err_event && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

    assign dbg_state = state;

endmodule
